mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// mem_arb -- two-port arbiter in front of a single-port synchronous memory.
// An instruction-fetch port (read only) and a data port (read/write) share
// one memory. Every transaction walks IDLE -> ISSUE -> RESP, which gives one
// access per three cycles.
//
// Optional feature macro: ARB_RR_EN
//   defined   : ties alternate between the ports (round-robin, fetch wins the
//               first tie after reset).
//   undefined : the data port wins every tie and no pointer is built.
//
// Handshake: a requester raises *_req with its address (and write data)
// and holds it until it sees its one-cycle *_ack. The request is captured
// on the rising edge where the arbiter is IDLE and sees *_req high. From
// then on the requester inputs are ignored for that transaction, and the
// ack still pulses if *_req is dropped. For reads, *_rdata is valid in the
// ack cycle and keeps that value until the next ack to the same port. A
// *_req still high in the cycle after its ack counts as a new request.
module mem_arb #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic          sel_d;      // latched winner: 1 = data port, 0 = fetch port
  logic          lat_we;     // latched write flag of the current transaction
  logic [DW-1:0] f_rdata_q;  // last fetch read result, held between acks
  logic [DW-1:0] d_rdata_q;  // last data read result, held between acks
  logic          pick_d;     // arbitration decision for this IDLE cycle

`ifdef ARB_RR_EN
  // Round-robin pointer: 1 means the data port was served last. It resets to
  // "data last" so that fetch wins the first tie.
  logic last_d;

  // Remember which port was served; updated in the ack cycle.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      last_d <= 1'b1;
    end else if (state == RESP) begin
      last_d <= sel_d;
    end
  end

  // On a tie the port that was not served last wins.
  assign pick_d = d_req & (~f_req | ~last_d);
`else
  // Fixed priority: the data port always wins a tie.
  assign pick_d = d_req;
`endif

  // Main FSM. The memory strobes, acks and busy are all registered here. The
  // asynchronous reset clears them the moment rst_f falls, so an access in
  // ISSUE is cut off before the memory can see another rising edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      sel_d     <= 1'b0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      busy      <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            // The memory address/data registers double as the transaction
            // latch, so later requester changes cannot leak in.
            state     <= ISSUE;
            sel_d     <= pick_d;
            lat_we    <= pick_d & d_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : f_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // The memory samples the access on this edge. The read data
          // appears during RESP, together with the ack.
          state  <= RESP;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          f_ack  <= ~sel_d;
          d_ack  <= sel_d;
        end
        RESP: begin
          // Capture the read data so the port keeps seeing it after the ack.
          state <= IDLE;
          busy  <= 1'b0;
          if (!sel_d) begin
            f_rdata_q <= mem_rdata;
          end else if (!lat_we) begin
            d_rdata_q <= mem_rdata;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Read data: in the ack cycle, pass the memory output straight through.
  // Otherwise, show the value captured at the last ack.
  always_comb begin
    f_rdata = f_rdata_q;
    d_rdata = d_rdata_q;
    if (f_ack) begin
      f_rdata = mem_rdata;
    end
    if (d_ack && !lat_we) begin
      d_rdata = mem_rdata;
    end
  end

  // Debug view of the FSM state.
  assign fsm_state = state;

endmodule
